// File: rtl/cv32e40x_pma_gate.sv
// Purpose: gates core bus requests on PMA violations and injects a PMA error response in order.
// Latency: requests/responses pass combinationally; PMA error response 1 cycle after drain completes.
// Backpressure: core ready follows bus ready; stalls when MAX_OUTSTANDING responses are pending.
module cv32e40x_pma_gate #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        core_trans_we_i,
    input  logic        pma_err_i,
    input  logic        pma_bufferable_i,
    input  logic        pma_cacheable_i,
    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_we_o,
    output logic        bus_trans_bufferable_o,
    output logic        bus_trans_cacheable_o,
    input  logic        bus_resp_valid_i,
    input  logic        bus_resp_err_i,
    output logic        core_resp_valid_o,
    output logic        core_resp_err_o,
    output logic        core_resp_pma_err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DRAIN = 2'd1,
        ERR_RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            room;
    logic            bus_hs;

    assign room = (cnt_q < MAX_CNT);

    // Address and attributes travel straight through; only valid is gated.
    assign bus_trans_addr_o       = core_trans_addr_i;
    assign bus_trans_we_o         = core_trans_we_i;
    assign bus_trans_bufferable_o = pma_bufferable_i;
    assign bus_trans_cacheable_o  = pma_cacheable_i;

    assign bus_hs = bus_trans_valid_o && bus_trans_ready_i;

    // Outstanding counter next value; a response with nothing pending is ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (bus_hs && !bus_resp_valid_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!bus_hs && bus_resp_valid_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Next state and handshake/response outputs.
    always_comb begin
        state_d             = state_q;
        bus_trans_valid_o   = 1'b0;
        core_trans_ready_o  = 1'b0;
        // Response passthrough is masked during reset so nothing reaches the core.
        core_resp_valid_o   = rst_n && bus_resp_valid_i;
        core_resp_err_o     = rst_n && bus_resp_valid_i && bus_resp_err_i;
        core_resp_pma_err_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus_trans_valid_o  = core_trans_valid_i && !pma_err_i && room;
                core_trans_ready_o = pma_err_i ? 1'b1 : (bus_trans_ready_i && room);
                if (core_trans_valid_i && pma_err_i) begin
                    // Older bus responses must reach the core before the error.
                    state_d = (cnt_d == '0) ? ERR_RESP : WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ERR_RESP;
                end
            end
            ERR_RESP: begin
                core_resp_valid_o   = 1'b1;
                core_resp_err_o     = 1'b0;
                core_resp_pma_err_o = 1'b1;
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and outstanding count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Nothing is outstanding while the injected error is presented, so a bus response is a protocol error.
    a_no_resp_in_err: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == ERR_RESP) && bus_resp_valid_i));

endmodule

// File: tb/tb_cv32e40x_pma_gate.sv
// Purpose: directed checks of the PMA gate: forwarding, error injection, drain ordering, reset.
// Latency: inputs applied 2ns after each rising edge, outputs checked 6ns after it.
// Backpressure: bus ready driven per vector; counter limit exercised with MAX_OUTSTANDING=2.
module tb_cv32e40x_pma_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_trans_valid_i;
    logic        core_trans_ready_o;
    logic [31:0] core_trans_addr_i;
    logic        core_trans_we_i;
    logic        pma_err_i;
    logic        pma_bufferable_i;
    logic        pma_cacheable_i;
    logic        bus_trans_valid_o;
    logic        bus_trans_ready_i;
    logic [31:0] bus_trans_addr_o;
    logic        bus_trans_we_o;
    logic        bus_trans_bufferable_o;
    logic        bus_trans_cacheable_o;
    logic        bus_resp_valid_i;
    logic        bus_resp_err_i;
    logic        core_resp_valid_o;
    logic        core_resp_err_o;
    logic        core_resp_pma_err_o;

    int total = 0;
    int bad   = 0;

    cv32e40x_pma_gate #(.MAX_OUTSTANDING(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .core_trans_valid_i     (core_trans_valid_i),
        .core_trans_ready_o     (core_trans_ready_o),
        .core_trans_addr_i      (core_trans_addr_i),
        .core_trans_we_i        (core_trans_we_i),
        .pma_err_i              (pma_err_i),
        .pma_bufferable_i       (pma_bufferable_i),
        .pma_cacheable_i        (pma_cacheable_i),
        .bus_trans_valid_o      (bus_trans_valid_o),
        .bus_trans_ready_i      (bus_trans_ready_i),
        .bus_trans_addr_o       (bus_trans_addr_o),
        .bus_trans_we_o         (bus_trans_we_o),
        .bus_trans_bufferable_o (bus_trans_bufferable_o),
        .bus_trans_cacheable_o  (bus_trans_cacheable_o),
        .bus_resp_valid_i       (bus_resp_valid_i),
        .bus_resp_err_i         (bus_resp_err_i),
        .core_resp_valid_o      (core_resp_valid_o),
        .core_resp_err_o        (core_resp_err_o),
        .core_resp_pma_err_o    (core_resp_pma_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        we, pe, bf, ca, br, rv, re;
        logic        x_cr, x_bv, x_rv, x_re, x_rp;
        int          x_cnt;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic v, logic [31:0] a, logic we, logic pe, logic bf, logic ca,
                                logic br, logic rv, logic re,
                                logic x_cr, logic x_bv, logic x_rv, logic x_re, logic x_rp, int x_cnt);
        vec_t t;
        t.v = v; t.a = a; t.we = we; t.pe = pe; t.bf = bf; t.ca = ca;
        t.br = br; t.rv = rv; t.re = re;
        t.x_cr = x_cr; t.x_bv = x_bv; t.x_rv = x_rv; t.x_re = x_re; t.x_rp = x_rp;
        t.x_cnt = x_cnt;
        return t;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] a, logic we, logic pe, logic bf, logic ca,
                         logic br, logic rv, logic re);
        core_trans_valid_i = v;  core_trans_addr_i = a;  core_trans_we_i = we;
        pma_err_i = pe;          pma_bufferable_i = bf;  pma_cacheable_i = ca;
        bus_trans_ready_i = br;  bus_resp_valid_i = rv;  bus_resp_err_i = re;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int cnt_now();
        logic [1:0] c;
        c = dut.cnt_q;
        return int'(c);
    endfunction

    function automatic int st_now();
        logic [1:0] s;
        s = dut.state_q;
        return int'(s);
    endfunction

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;
    localparam logic [31:0] A2 = 32'h2000_0080;
    localparam logic [31:0] AB = 32'h3000_1234;
    localparam logic [31:0] AC = 32'h8000_00FC;

    initial begin
        //          v  addr we pe bf ca br rv re   cr bv rv re rp cnt
        vecs[0]  = mk(0, A0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, A0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0); // error, nothing pending
        vecs[2]  = mk(0, A0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0); // error response
        vecs[3]  = mk(0, A0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // only one cycle
        vecs[4]  = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0); // load 1
        vecs[5]  = mk(1, A2, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1); // load 2
        vecs[6]  = mk(1, A0, 0, 1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 2); // error with 2 pending
        vecs[7]  = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2); // draining, no issue
        vecs[8]  = mk(1, A1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 2); // resp 1
        vecs[9]  = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[10] = mk(1, A1, 0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 1, 0, 1); // resp 2 with bus error
        vecs[11] = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 1, 0); // pma error response
        vecs[12] = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0); // back in IDLE
        vecs[13] = mk(1, A2, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1);
        vecs[14] = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2); // full
        vecs[15] = mk(1, A1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2);
        vecs[16] = mk(1, A1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 2); // resp frees a slot
        vecs[17] = mk(1, A1, 0, 0, 0, 0, 1, 1, 1,  1, 1, 1, 1, 0, 1); // hs + resp same cycle
        vecs[18] = mk(0, A1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1); // count held at 1
        vecs[19] = mk(1, AB, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1); // stalled
        vecs[20] = mk(1, AB, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1); // still stalled
        vecs[21] = mk(1, AB, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1); // accepted
        vecs[22] = mk(0, AB, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 2);
        vecs[23] = mk(0, AB, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1);
        vecs[24] = mk(0, AB, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0); // stray resp at 0
        vecs[25] = mk(0, AB, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // no underflow
        vecs[26] = mk(1, AC, 1, 0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0); // bufferable cacheable store
        vecs[27] = mk(0, AC, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1);
        vecs[28] = mk(0, AC, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        // Reset state, with a response pulse that must not reach the core.
        rst_n = 1'b0;
        idle_in();
        bus_resp_valid_i = 1'b1;
        #3;
        chk("rst_resp_valid", -1, 32'(core_resp_valid_o), 32'd0);
        chk("rst_resp_pma",   -1, 32'(core_resp_pma_err_o), 32'd0);
        chk("rst_bus_valid",  -1, 32'(bus_trans_valid_o), 32'd0);
        chk("rst_cnt",        -1, 32'(cnt_now()), 32'd0);
        chk("rst_state",      -1, 32'(st_now()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        idle_in();
        rst_n = 1'b1;

        // Table: drive at +2 after posedge, check at +6 (mid cycle).
        @(posedge clk);
        for (int i = 0; i < 29; i++) begin
            #2;
            drive(vecs[i].v, vecs[i].a, vecs[i].we, vecs[i].pe, vecs[i].bf, vecs[i].ca,
                  vecs[i].br, vecs[i].rv, vecs[i].re);
            #4;
            chk("core_ready", i, 32'(core_trans_ready_o), 32'(vecs[i].x_cr));
            chk("bus_valid",  i, 32'(bus_trans_valid_o),  32'(vecs[i].x_bv));
            chk("resp_valid", i, 32'(core_resp_valid_o),  32'(vecs[i].x_rv));
            chk("resp_err",   i, 32'(core_resp_err_o),    32'(vecs[i].x_re));
            chk("resp_pma",   i, 32'(core_resp_pma_err_o), 32'(vecs[i].x_rp));
            chk("cnt",        i, 32'(cnt_now()),          32'(vecs[i].x_cnt));
            chk("bus_addr",   i, bus_trans_addr_o,        vecs[i].a);
            chk("bus_attr",   i, {29'd0, bus_trans_we_o, bus_trans_bufferable_o, bus_trans_cacheable_o},
                {29'd0, vecs[i].we, vecs[i].bf, vecs[i].ca});
            @(posedge clk);
        end

        // Reset during WAIT_DRAIN with one response pending.
        #2; drive(1'b1, A1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2; drive(1'b1, A0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2; idle_in();
        #4;
        chk("wd_state", 100, 32'(st_now()), 32'd1);
        chk("wd_cnt",   100, 32'(cnt_now()), 32'd1);
        rst_n = 1'b0;
        bus_resp_valid_i = 1'b1;
        #1;
        chk("wd_rst_cnt",   101, 32'(cnt_now()), 32'd0);
        chk("wd_rst_state", 101, 32'(st_now()), 32'd0);
        chk("wd_rst_rv",    101, 32'(core_resp_valid_o), 32'd0);
        @(posedge clk);
        #2; idle_in(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("wd_post_pma", 110 + k, 32'(core_resp_pma_err_o), 32'd0);
            chk("wd_post_rv",  110 + k, 32'(core_resp_valid_o), 32'd0);
            chk("wd_post_cnt", 110 + k, 32'(cnt_now()), 32'd0);
            @(posedge clk);
            #2;
        end

        // Reset during ERR_RESP drops the injected response at once.
        drive(1'b1, A0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2; idle_in();
        #1;
        chk("er_pma_before", 120, 32'(core_resp_pma_err_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("er_pma_rst", 121, 32'(core_resp_pma_err_o), 32'd0);
        chk("er_rv_rst",  121, 32'(core_resp_valid_o), 32'd0);
        @(posedge clk);
        #2; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("er_post_pma",   130 + k, 32'(core_resp_pma_err_o), 32'd0);
            chk("er_post_state", 130 + k, 32'(st_now()), 32'd0);
            @(posedge clk);
            #2;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_pma_gate.md
CV32E40X_PMA_GATE -- requirements
Module: cv32e40x_pma_gate

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of bus transactions awaiting a response (legal 1..7).
REQ-002 SHALL have port clk  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port core_trans_valid_i  input  1  core transaction request.
REQ-005 SHALL have port core_trans_ready_o  output  1  transaction accepted from core.
REQ-006 SHALL have port core_trans_addr_i  input  32  byte address.
REQ-007 SHALL have port core_trans_we_i  input  1  write enable.
REQ-008 SHALL have port pma_err_i  input  1  PMA violation for the current core_trans_addr_i (combinational, same cycle).
REQ-009 SHALL have ports pma_bufferable_i and pma_cacheable_i  input  1 each  PMA attributes for the current address.
REQ-010 SHALL have port bus_trans_valid_o  output  1  bus request.
REQ-011 SHALL have port bus_trans_ready_i  input  1  bus accepts request.
REQ-012 SHALL have ports bus_trans_addr_o (32), bus_trans_we_o (1), bus_trans_bufferable_o (1), bus_trans_cacheable_o (1)  output  combinational copies of the core/PMA inputs.
REQ-013 SHALL have ports bus_resp_valid_i and bus_resp_err_i  input  1 each  bus response and bus error.
REQ-014 SHALL have ports core_resp_valid_o, core_resp_err_o and core_resp_pma_err_o  output  1 each  response to core, bus error, PMA error.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_DRAIN, ERR_RESP plus a registered outstanding counter cnt_q of width clog2(MAX_OUTSTANDING+1).
REQ-016 In IDLE, bus_trans_valid_o SHALL be core_trans_valid_i && !pma_err_i && (cnt_q < MAX_OUTSTANDING); 0 in all other states.
REQ-017 In IDLE, core_trans_ready_o SHALL be 1 when pma_err_i=1, else bus_trans_ready_i && (cnt_q < MAX_OUTSTANDING); 0 in all other states.
REQ-018 cnt_q SHALL increment on bus_trans_valid_o && bus_trans_ready_i, decrement on bus_resp_valid_i, and remain unchanged when both occur in the same cycle.
REQ-019 bus_resp_valid_i with cnt_q=0 and no same-cycle handshake SHALL leave cnt_q at 0 (no underflow).
REQ-020 IDLE with core_trans_valid_i && pma_err_i: transaction accepted, never forwarded; next state ERR_RESP if next cnt is 0, else WAIT_DRAIN.
REQ-021 WAIT_DRAIN SHALL forward bus responses and move to ERR_RESP in the cycle after next cnt reaches 0.
REQ-022 ERR_RESP SHALL last exactly one cycle with core_resp_valid_o=1, core_resp_pma_err_o=1, core_resp_err_o=0, then return to IDLE.
REQ-023 Outside ERR_RESP: core_resp_valid_o=bus_resp_valid_i, core_resp_err_o=bus_resp_valid_i && bus_resp_err_i, core_resp_pma_err_o=0.
REQ-024 Error-response latency with cnt_q=0 at acceptance SHALL be exactly 1 cycle; responses SHALL return to the core in request order.
REQ-025 bus_resp_valid_i during ERR_RESP is illegal (cnt_q=0); the block SHALL flag it with an assertion.
REQ-026 A request stalled by bus_trans_ready_i=0 SHALL keep bus_trans_valid_o and the bus address stable while the core holds its inputs stable.

Reset
REQ-027 While rst_n=0: state IDLE, cnt_q=0, core_resp_valid_o=0, core_resp_pma_err_o=0, bus_trans_valid_o=0 unless combinationally driven by core inputs per REQ-016.
REQ-028 Reset asserted mid-WAIT_DRAIN or mid-ERR_RESP SHALL discard the pending error response and clear the outstanding count.

Verification
REQ-029 cnt_q=0, valid with pma_err_i=1 at 0x1000_0000 -> ready=1 same cycle, bus_trans_valid_o=0, core_resp_valid_o=1 with pma_err=1 in the next cycle only.
REQ-030 Two accepted bus loads (cnt_q=2), then an error request -> WAIT_DRAIN; two bus responses return; pma_err response arrives the cycle after the second; no third bus request issued.
REQ-031 MAX_OUTSTANDING=2, bus ready=1 with no responses -> third request sees ready=0, bus_trans_valid_o=0 until one response returns.
REQ-032 cnt_q=1, same-cycle handshake and bus_resp_valid_i -> cnt_q stays 1; bus_resp_err_i=1 -> core_resp_err_o=1, core_resp_pma_err_o=0.
REQ-033 rst_n low during WAIT_DRAIN with cnt_q=1 -> after release, state IDLE, cnt_q=0, no pma_err response emitted.
REQ-034 Store to bufferable, cacheable region -> bus_trans_bufferable_o=1, bus_trans_cacheable_o=1, bus_trans_we_o=1, addr passed unchanged.
